spi_master_arbiter: RTL and testbench

Shares one SPI master (start/finish/data handshake) between NUM_REQ requesters using round-robin arbitration. Drives one active-low chip select per requester and sequences each transfer: CS setup, one-cycle start pulse, wait for the finish edge, then CS hold. It sits between the system-side clients and the SPI master inside the SPI top level.

---
 rtl/spi_master_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin share of one SPI master between NUM_REQ clients, one active-low CS each.
// Latency: req seen in IDLE -> spi_start after CS_SETUP+2 clk; finish edge -> ack 1 clk, -> CS release CS_HOLD+1 clk.
// Backpressure: req is a level held until ack, sampled only in IDLE; a single transfer is in flight at a time.
// Option: define SPI_ARB_TIMEOUT_EN to abort a WAIT with err after TIMEOUT cycles without a finish edge.
module spi_master_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter int TIMEOUT    = 1023
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         rx_data,
   output logic                          err,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic [DATA_WIDTH-1:0]         spi_data_in,
   output logic                          spi_start,
   input  logic                          spi_finish,
   input  logic [DATA_WIDTH-1:0]         spi_data_out,
   output logic [NUM_REQ-1:0]            cs_n
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CNT_MAX = (TIMEOUT > MAX_SH) ? TIMEOUT : MAX_SH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_START,
      S_WAIT,
      S_HOLD,
      S_REL
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]      cnt;
   logic                  cnt_run;
   logic [IDX_W-1:0]      ptr, sel;
   logic [IDX_W-1:0]      pick, cidx;
   int                    cand;
   logic                  found;
   logic                  finish_d;
   logic                  fin_edge;
   logic                  setup_done, hold_done, tmo_hit;
   logic [DATA_WIDTH-1:0] tx_sel;

   logic [NUM_REQ-1:0]    grant_nxt, cs_n_nxt, ack_nxt;
   logic [DATA_WIDTH-1:0] spi_data_in_nxt, rx_data_nxt;
   logic                  spi_start_nxt;
   logic [IDX_W-1:0]      ptr_nxt, sel_nxt;

   // A finish level that was already high before WAIT never counts: only a low-to-high step does.
   assign fin_edge   = spi_finish & ~finish_d;
   assign setup_done = (cnt == CNT_W'(CS_SETUP - 1));
   assign hold_done  = (cnt == CNT_W'(CS_HOLD - 1));
   assign busy       = (state != S_IDLE);

`ifdef SPI_ARB_TIMEOUT_EN
   logic err_nxt;
   assign tmo_hit = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT - 1));
   assign cnt_run = (state == S_SETUP) || (state == S_HOLD) || (state == S_WAIT);
`else
   assign tmo_hit = 1'b0;
   assign cnt_run = (state == S_SETUP) || (state == S_HOLD);
   assign err     = 1'b0;
`endif

   // Round-robin pick: first set request at or after ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      cidx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         cidx = cand[IDX_W-1:0];
         if (!found && req[cidx]) begin
            found = 1'b1;
            pick  = cidx;
         end
      end
   end

   // Word of the picked requester.
   always_comb begin
      tx_sel = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick == IDX_W'(k)) begin
            tx_sel = tx_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state sequencing: setup, start, wait for finish, hold, release.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found) state_nxt = S_SETUP;
         S_SETUP: if (setup_done) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (fin_edge || tmo_hit) state_nxt = S_HOLD;
         S_HOLD:  if (hold_done) state_nxt = S_REL;
         S_REL:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; pulses default low, everything else holds.
   always_comb begin
      grant_nxt       = grant;
      cs_n_nxt        = cs_n;
      spi_data_in_nxt = spi_data_in;
      rx_data_nxt     = rx_data;
      ptr_nxt         = ptr;
      sel_nxt         = sel;
      ack_nxt         = '0;
      spi_start_nxt   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_nxt         = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (found) begin
               grant_nxt       = ONE_HOT0 << pick;
               cs_n_nxt        = ~(ONE_HOT0 << pick);
               spi_data_in_nxt = tx_sel;
               sel_nxt         = pick;
            end
         end
         S_START: begin
            spi_start_nxt = 1'b1;
         end
         S_WAIT: begin
            if (fin_edge) begin
               rx_data_nxt = spi_data_out;
               ack_nxt     = grant;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               rx_data_nxt = '0;
               ack_nxt     = grant;
               err_nxt     = 1'b1;
            end
`endif
         end
         S_REL: begin
            grant_nxt = '0;
            cs_n_nxt  = '1;
            ptr_nxt   = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output, pointer, finish-history and phase-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant       <= '0;
         cs_n        <= '1;
         spi_data_in <= '0;
         rx_data     <= '0;
         ack         <= '0;
         spi_start   <= 1'b0;
         ptr         <= '0;
         sel         <= '0;
         finish_d    <= 1'b0;
         cnt         <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         err         <= 1'b0;
`endif
      end else begin
         grant       <= grant_nxt;
         cs_n        <= cs_n_nxt;
         spi_data_in <= spi_data_in_nxt;
         rx_data     <= rx_data_nxt;
         ack         <= ack_nxt;
         spi_start   <= spi_start_nxt;
         ptr         <= ptr_nxt;
         sel         <= sel_nxt;
         finish_d    <= spi_finish;
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (cnt_run) begin
            cnt <= cnt + 1'b1;
         end
`ifdef SPI_ARB_TIMEOUT_EN
         err         <= err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter with a transaction-level round-robin model.
module tb_spi_master_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;
   localparam int TMO   = 1023;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req;
   logic [NR*DW-1:0] tx_data;
   logic [NR-1:0]   ack;
   logic [DW-1:0]   rx_data;
   logic            err;
   logic [NR-1:0]   grant;
   logic            busy;
   logic [DW-1:0]   spi_data_in;
   logic            spi_start;
   logic            spi_finish;
   logic [DW-1:0]   spi_data_out;
   logic [NR-1:0]   cs_n;

   int              n_tests = 0;
   int              n_fail  = 0;
   bit              mon_en  = 1'b0;

   int              m_ptr;
   logic [DW-1:0]   m_last_rx;
   logic [DW-1:0]   tx_w [NR];

   spi_master_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .CS_SETUP  (SETUP),
      .CS_HOLD   (HOLD),
      .TIMEOUT   (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .tx_data     (tx_data),
      .ack         (ack),
      .rx_data     (rx_data),
      .err         (err),
      .grant       (grant),
      .busy        (busy),
      .spi_data_in (spi_data_in),
      .spi_start   (spi_start),
      .spi_finish  (spi_finish),
      .spi_data_out(spi_data_out),
      .cs_n        (cs_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // At most one chip select may ever be low.
   always @(negedge clk) begin
      if (mon_en) check("cs_onehot", 32'($countones(~cs_n) <= 1), 1);
   end

   task automatic load_tx();
      for (int i = 0; i < NR; i++) begin
         tx_w[i] = 8'($urandom_range(0, 255));
         tx_data[i*DW +: DW] = tx_w[i];
      end
   endtask

   task automatic set_tx(input int idx, input logic [DW-1:0] v);
      tx_w[idx] = v;
      tx_data[idx*DW +: DW] = v;
   endtask

   function automatic int rr_pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         if (r[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   // One complete transfer, called with the DUT in IDLE; returns at the first IDLE cycle after release.
   task automatic run_xfer(input logic [NR-1:0] new_bits, input bit pre_high, input int fdly,
                           input logic [DW-1:0] rxw, output int win);
      int            w, sc;
      bit            seen, got_ack;
      logic [NR-1:0] exp_g, exp_cs;
      req    = req | new_bits;
      w      = rr_pick(req, m_ptr);
      win    = w;
      exp_g  = 4'b0001 << w;
      exp_cs = ~exp_g;
      seen   = 1'b0;
      sc     = 0;
      got_ack = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         tick();
         if (spi_start) begin
            seen = 1'b1;
            sc   = c;
         end else begin
            check("setup_cs", cs_n, exp_cs);
            check("setup_grant", grant, exp_g);
            check("setup_busy", busy, 1);
         end
         check("tx_word", spi_data_in, tx_w[w]);
         if (pre_high && c == 1) begin
            spi_finish   = 1'b1;
            spi_data_out = 8'hEE;
         end
      end
      check("start_seen", seen, 1);
      check("start_lat", sc, SETUP + 2);
      check("rx_hold", rx_data, m_last_rx);
      for (int k = 1; k <= fdly; k++) begin
         tick();
         if (k == 1) check("start_width", spi_start, 0);
         if (ack != '0) got_ack = 1'b1;
         check("wait_cs", cs_n, exp_cs);
         check("wait_tx", spi_data_in, tx_w[w]);
      end
      if (pre_high) begin
         spi_finish = 1'b0;
         tick();
         if (ack != '0) got_ack = 1'b1;
      end
      check("no_early_ack", got_ack, 0);
      spi_finish   = 1'b1;
      spi_data_out = rxw;
      tick();
      check("ack", ack, exp_g);
      check("rx_data", rx_data, rxw);
      check("err_clr", err, 0);
      check("ack_cs", cs_n, exp_cs);
      spi_finish = 1'b0;
      req        = req & ~exp_g;
      m_last_rx  = rxw;
      for (int c = 2; c <= HOLD + 1; c++) begin
         tick();
         check("ack_width", ack, 0);
         check("hold_cs", cs_n, exp_cs);
         check("hold_tx", spi_data_in, tx_w[w]);
      end
      tick();
      check("rel_cs", cs_n, 4'hF);
      check("rel_grant", grant, 0);
      check("rel_busy", busy, 0);
      m_ptr = (w + 1) % NR;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            win, sc;
      bit            seen, got_ack, all_busy;
      logic [NR-1:0] bits;
      int            rr_exp [5] = '{0, 1, 2, 3, 0};

      rst          = 1'b1;
      req          = '0;
      tx_data      = '0;
      spi_finish   = 1'b0;
      spi_data_out = '0;
      m_ptr        = 0;
      m_last_rx    = '0;
      tick();
      tick();
      check("rst_cs", cs_n, 4'hF);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_ack", ack, 0);
      check("rst_rx", rx_data, 0);
      check("rst_err", err, 0);
      check("rst_start", spi_start, 0);
      check("rst_txw", spi_data_in, 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Persistent requests from everyone: strict rotation.
      for (int i = 0; i < 5; i++) begin
         load_tx();
         run_xfer(4'b1111, 1'b0, 2, 8'($urandom_range(0, 255)), win);
         check("rr_order", win, rr_exp[i]);
      end

      // Single requester with a known word pair.
      req = '0;
      load_tx();
      set_tx(1, 8'hA5);
      run_xfer(4'b0010, 1'b0, 3, 8'h3C, win);
      check("single_win", win, 1);

      // Reset while waiting for finish aborts without ack.
      load_tx();
      req  = 4'b0100;
      seen = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         tick();
         if (spi_start) seen = 1'b1;
      end
      check("rst_wait_start", seen, 1);
      tick(); tick(); tick();
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      check("abort_cs", cs_n, 4'hF);
      check("abort_grant", grant, 0);
      check("abort_busy", busy, 0);
      check("abort_ack", ack, 0);
      check("abort_rx", rx_data, 0);
      spi_finish   = 1'b1;
      spi_data_out = 8'h77;
      got_ack      = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         spi_finish = 1'b0;
         if (ack != '0) got_ack = 1'b1;
      end
      check("abort_no_ack", got_ack, 0);
      m_ptr     = 0;
      m_last_rx = '0;
      load_tx();
      run_xfer(4'b0001, 1'b0, 2, 8'h96, win);
      check("recover_win", win, 0);

      // Finish already high before start: only a fresh rising edge completes.
      load_tx();
      run_xfer(4'b1000, 1'b1, 4, 8'h5A, win);
      check("prehigh_win", win, 3);

      // Random request mixes against the round-robin model.
      for (int i = 0; i < 30; i++) begin
         load_tx();
         bits = 4'($urandom_range(0, 15));
         if ((req | bits) == '0) bits = 4'b0001 << $urandom_range(0, 3);
         run_xfer(bits, ($urandom_range(0, 5) == 0), int'($urandom_range(1, 6)),
                  8'($urandom_range(0, 255)), win);
      end

      // Stuck master: finish never rises.
      req = '0;
      load_tx();
      req  = 4'b0100;
      seen = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         tick();
         if (spi_start) seen = 1'b1;
      end
      check("stuck_start", seen, 1);
`ifdef SPI_ARB_TIMEOUT_EN
      got_ack = 1'b0;
      sc      = 0;
      for (int c = 1; c <= TMO + 10 && !got_ack; c++) begin
         tick();
         if (ack != '0) begin
            got_ack = 1'b1;
            sc      = c;
            check("tmo_ack", ack, 4'b0100);
            check("tmo_err", err, 1);
            check("tmo_rx", rx_data, 0);
         end
      end
      check("tmo_seen", got_ack, 1);
      check("tmo_lat", sc, TMO);
`else
      got_ack  = 1'b0;
      all_busy = 1'b1;
      for (int c = 0; c < 1100; c++) begin
         tick();
         if (ack != '0) got_ack = 1'b1;
         if (!busy) all_busy = 1'b0;
      end
      check("stuck_no_ack", got_ack, 0);
      check("stuck_busy", all_busy, 1);
      check("stuck_err", err, 0);
      sc = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
